ofm_word_packer: RTL

// - Upstream feeder for the router's branch/trunk inputs.
// - Takes one BIT_OFM-bit OFM pixel per cycle from the convolution datapath and packs HOW_MANY_PIXEL pixels into one WIRE_NUM-bit word.
// - Pushes each word into a router input FIFO using the write/full handshake.
// - A 2-entry output queue absorbs router back-pressure; pixel-side back-pressure is signalled with pix_ready.

---
 rtl/ofm_word_packer_pkg.sv | 30 +++
 rtl/ofm_word_packer_if.sv | 24 ++
 rtl/ofm_skid_queue.sv | 70 +++++++
 rtl/ofm_word_packer.sv | 102 ++++++++++
 4 files changed

// File: rtl/ofm_word_packer_pkg.sv
// Shared width derivations for the OFM word packer and the router it feeds.
// Both sides call these functions so their packed-word widths always agree.
package ofm_word_packer_pkg;

    typedef logic [1:0] q_cnt_t;

    localparam q_cnt_t Q_DEPTH = 2'd2;

    function automatic int calc_num_cycle(input int bottleneck, input int ou, input int delta_x);
        return (bottleneck * ou) / delta_x;
    endfunction

    function automatic int calc_data_amount(input int k, input int out_ch);
        return k * out_ch;
    endfunction

    function automatic int calc_how_many_pixel(input int data_amount, input int num_cycle);
        return (data_amount + num_cycle - 1) / num_cycle;
    endfunction

    function automatic int calc_wire_num(input int how_many_pixel, input int bit_ofm);
        return how_many_pixel * bit_ofm;
    endfunction

    // Counter width that stays legal (>= 1 bit) even for a single-value range.
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofm_word_packer_if.sv
// Pixel-side valid/ready and router-side write/full signals of the OFM word packer.
interface ofm_word_packer_if #(
    parameter int BIT_OFM  = 29,
    parameter int WIRE_NUM = 29
);
    logic                pix_valid;
    logic [BIT_OFM-1:0]  pix_data;
    logic                pix_ready;
    logic                dst_full;
    logic [WIRE_NUM-1:0] dst_data;
    logic                dst_write;
    logic                frame_done;

    modport master (
        input  pix_valid, pix_data, dst_full,
        output pix_ready, dst_data, dst_write, frame_done
    );

    modport slave (
        output pix_valid, pix_data, dst_full,
        input  pix_ready, dst_data, dst_write, frame_done
    );

endinterface

// File: rtl/ofm_skid_queue.sv
// Two-entry {word, last} FIFO absorbing router back-pressure.
// The head is forced to zero while the queue is empty.
module ofm_skid_queue
    import ofm_word_packer_pkg::*;
#(
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_word,
    output logic             head_last,
    output q_cnt_t           cnt
);

    logic [WIDTH-1:0] word_r [2];
    logic [1:0]       last_r;
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    q_cnt_t           cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Overflow/underflow guards keep the storage consistent even under misuse.
    assign push_ok_s = push & (cnt_r != Q_DEPTH);
    assign pop_ok_s  = pop & (cnt_r != 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r[0] <= {WIDTH{1'b0}};
            word_r[1] <= {WIDTH{1'b0}};
            last_r    <= 2'b00;
            rd_ptr_r  <= 1'b0;
            wr_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
        end else begin
            if (push_ok_s) begin
                word_r[wr_ptr_r] <= push_word;
                last_r[wr_ptr_r] <= push_last;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Head presentation.
    always_comb begin
        if (cnt_r != 2'd0) begin
            head_word = word_r[rd_ptr_r];
            head_last = last_r[rd_ptr_r];
        end else begin
            head_word = {WIDTH{1'b0}};
            head_last = 1'b0;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/ofm_word_packer.sv
// Packs HOW_MANY_PIXEL OFM pixels per router word and pushes words through a
// two-entry queue into the router input FIFO; the final word of a frame may be short.
module ofm_word_packer
    import ofm_word_packer_pkg::*;
#(
    parameter int K          = 3,
    parameter int BOTTLENECK = 1668,
    parameter int BIT_OFM    = 29,
    parameter int DELTA_X    = 16,
    parameter int OU         = 8,
    parameter int OUT_CH     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    ofm_word_packer_if.master bus
);

    localparam int NUM_CYCLE      = calc_num_cycle(BOTTLENECK, OU, DELTA_X);
    localparam int DATA_AMOUNT    = calc_data_amount(K, OUT_CH);
    localparam int HOW_MANY_PIXEL = calc_how_many_pixel(DATA_AMOUNT, NUM_CYCLE);
    localparam int WIRE_NUM       = calc_wire_num(HOW_MANY_PIXEL, BIT_OFM);
    localparam int LANE_W         = calc_width(HOW_MANY_PIXEL);
    localparam int CNT_W          = calc_width(DATA_AMOUNT);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(HOW_MANY_PIXEL - 1);
    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(DATA_AMOUNT - 1);

    logic [LANE_W-1:0]   lane_r;
    logic [CNT_W-1:0]    pix_cnt_r;
    logic [WIRE_NUM-1:0] collect_r;
    logic [WIRE_NUM-1:0] word_s;
    logic                frame_done_r;
    logic                accept_s;
    logic                last_pix_s;
    logic                close_s;
    logic                pix_ready_s;
    logic                dst_write_s;
    logic [WIRE_NUM-1:0] head_word_s;
    logic                head_last_s;
    q_cnt_t              q_cnt_s;

    // Ready only looks at occupancy; a same-cycle pop does not free a slot early.
    assign pix_ready_s = (q_cnt_s != Q_DEPTH);
    assign accept_s    = bus.pix_valid & pix_ready_s;
    assign last_pix_s  = (pix_cnt_r == LAST_PIX);
    assign close_s     = accept_s & ((lane_r == LAST_LANE) | last_pix_s);
    assign dst_write_s = (q_cnt_s != 2'd0) & ~bus.dst_full;

    // Candidate word: the partial word with the incoming pixel dropped into its lane.
    always_comb begin
        word_s = collect_r;
        for (int i = 0; i < HOW_MANY_PIXEL; i++) begin
            if (lane_r == LANE_W'(i)) begin
                word_s[i*BIT_OFM +: BIT_OFM] = bus.pix_data;
            end else begin
                word_s[i*BIT_OFM +: BIT_OFM] = collect_r[i*BIT_OFM +: BIT_OFM];
            end
        end
    end

    // Lane / frame counters, partial-word register and the frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r       <= {LANE_W{1'b0}};
            pix_cnt_r    <= {CNT_W{1'b0}};
            collect_r    <= {WIRE_NUM{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= dst_write_s & head_last_s;
            if (accept_s) begin
                pix_cnt_r <= last_pix_s ? {CNT_W{1'b0}} : (pix_cnt_r + CNT_W'(1));
                if (close_s) begin
                    lane_r    <= {LANE_W{1'b0}};
                    collect_r <= {WIRE_NUM{1'b0}};
                end else begin
                    lane_r    <= lane_r + LANE_W'(1);
                    collect_r <= word_s;
                end
            end
        end
    end

    ofm_skid_queue #(
        .WIDTH (WIRE_NUM)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (close_s),
        .push_word (word_s),
        .push_last (last_pix_s),
        .pop       (dst_write_s),
        .head_word (head_word_s),
        .head_last (head_last_s),
        .cnt       (q_cnt_s)
    );

    assign bus.pix_ready  = pix_ready_s;
    assign bus.dst_write  = dst_write_s;
    assign bus.dst_data   = head_word_s;
    assign bus.frame_done = frame_done_r;

endmodule
